// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core.
// Holds the TX/RX state encodings, the idle line level and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic IDLE_LVL   = 1'b1;
  localparam int   MAX_DATA_W = 9;

  // Callers zero-extend narrower words; zero bits do not change the XOR.
  function automatic logic calc_par(input logic [MAX_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered pointers.
// A push while full is dropped even when a pop lands in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_core_p.sv
// Parametrised UART core: shared oversampling divider, TX/RX FSMs, FIFOs and sticky errors.
// Both directions run off clock-enable ticks; there are no derived clocks.
module uart_core_p
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int OSR        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic              cfg_stop2,
  input  logic              cfg_tx_en,
  input  logic              cfg_rx_en,
  input  logic              tx_wr,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_full,
  output logic              tx_empty,
  output logic              tx_busy,
  input  logic              rx_rd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              err_clr,
  output logic              rx_overrun,
  output logic              rx_par_err,
  output logic              rx_frame_err,
  input  logic              rxd,
  output logic              txd
);

  localparam int TW = $clog2(OSR);
  localparam int BW = $clog2(DATA_W);
  localparam logic [TW-1:0] T_LAST = TW'(OSR - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OSR / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

  logic [DIV_W-1:0] cfg_div_r;
  logic             cfg_par_en_r;
  logic             cfg_par_odd_r;
  logic             cfg_stop2_r;
  logic             cfg_tx_en_r;
  logic             cfg_rx_en_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_div_r     <= '0;
      cfg_par_en_r  <= 1'b0;
      cfg_par_odd_r <= 1'b0;
      cfg_stop2_r   <= 1'b0;
      cfg_tx_en_r   <= 1'b0;
      cfg_rx_en_r   <= 1'b0;
    end else if (cfg_wr) begin
      cfg_div_r     <= cfg_div;
      cfg_par_en_r  <= cfg_par_en;
      cfg_par_odd_r <= cfg_par_odd;
      cfg_stop2_r   <= cfg_stop2;
      cfg_tx_en_r   <= cfg_tx_en;
      cfg_rx_en_r   <= cfg_rx_en;
    end
  end

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == cfg_div_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      div_cnt <= '0;
    else if (cfg_wr) div_cnt <= '0;
    else if (tick)   div_cnt <= '0;
    else             div_cnt <= div_cnt + DIV_W'(1);
  end

  logic [DATA_W-1:0] tx_head;
  logic              tx_pop;
  logic              rx_push;
  logic              rx_full;
  logic              rx_empty;
  logic [DATA_W-1:0] rx_shift;

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_wr),
    .wdata (tx_data),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .wdata (rx_shift),
    .pop   (rx_rd),
    .rdata (rx_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign rx_valid = !rx_empty;

  // Transmitter
  tx_state_t         tx_state, tx_state_nxt;
  logic [TW-1:0]     tx_tcnt, tx_tcnt_nxt;
  logic [BW-1:0]     tx_bcnt, tx_bcnt_nxt;
  logic [DATA_W-1:0] tx_shift, tx_shift_nxt;
  logic              tx_par, tx_par_nxt;
  logic              tx_stop, tx_stop_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_stop  <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_tcnt  <= tx_tcnt_nxt;
      tx_bcnt  <= tx_bcnt_nxt;
      tx_shift <= tx_shift_nxt;
      tx_par   <= tx_par_nxt;
      tx_stop  <= tx_stop_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_tcnt_nxt  = tx_tcnt;
    tx_bcnt_nxt  = tx_bcnt;
    tx_shift_nxt = tx_shift;
    tx_par_nxt   = tx_par;
    tx_stop_nxt  = tx_stop;
    tx_pop       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tick && cfg_tx_en_r && !tx_empty) begin
          tx_pop       = 1'b1;
          tx_shift_nxt = tx_head;
          // Parity is latched with the word so a later cfg change cannot split it.
          tx_par_nxt   = calc_par(MAX_DATA_W'(tx_head), cfg_par_odd_r);
          tx_tcnt_nxt  = '0;
          tx_state_nxt = TX_START;
        end
      end
      default: begin
        if (tick) begin
          if (tx_tcnt != T_LAST) begin
            tx_tcnt_nxt = tx_tcnt + TW'(1);
          end else begin
            tx_tcnt_nxt = '0;
            case (tx_state)
              TX_START: begin
                tx_bcnt_nxt  = '0;
                tx_state_nxt = TX_DATA;
              end
              TX_DATA: begin
                tx_shift_nxt = tx_shift >> 1;
                if (tx_bcnt == B_LAST) begin
                  tx_stop_nxt  = 1'b0;
                  tx_state_nxt = cfg_par_en_r ? TX_PARITY : TX_STOP;
                end else begin
                  tx_bcnt_nxt = tx_bcnt + BW'(1);
                end
              end
              TX_PARITY: begin
                tx_stop_nxt  = 1'b0;
                tx_state_nxt = TX_STOP;
              end
              TX_STOP: begin
                if (cfg_stop2_r && !tx_stop) tx_stop_nxt  = 1'b1;
                else                         tx_state_nxt = TX_IDLE;
              end
              default: tx_state_nxt = TX_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    txd = IDLE_LVL;
    case (tx_state)
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_shift[0];
      TX_PARITY: txd = tx_par;
      default:   txd = IDLE_LVL;
    endcase
  end

  assign tx_busy = (tx_state != TX_IDLE);

  // Receiver: two-flop synchroniser plus one history flop for edge detect
  logic [1:0] rx_sync;
  logic       rx_prev;
  logic       rx_line;
  logic       rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= {2{IDLE_LVL}};
      rx_prev <= IDLE_LVL;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      rx_prev <= rx_sync[1];
    end
  end

  assign rx_line = rx_sync[1];
  assign rx_fall = rx_prev && !rx_line;

  rx_state_t         rx_state, rx_state_nxt;
  logic [TW-1:0]     rx_tcnt, rx_tcnt_nxt;
  logic [BW-1:0]     rx_bcnt, rx_bcnt_nxt;
  logic [DATA_W-1:0] rx_shift_nxt;
  logic              rx_par, rx_par_nxt;
  logic              par_evt;
  logic              frame_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bcnt  <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_tcnt  <= rx_tcnt_nxt;
      rx_bcnt  <= rx_bcnt_nxt;
      rx_shift <= rx_shift_nxt;
      rx_par   <= rx_par_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_tcnt_nxt  = rx_tcnt;
    rx_bcnt_nxt  = rx_bcnt;
    rx_shift_nxt = rx_shift;
    rx_par_nxt   = rx_par;
    rx_push      = 1'b0;
    par_evt      = 1'b0;
    frame_evt    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (cfg_rx_en_r && rx_fall) begin
          rx_tcnt_nxt  = '0;
          rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_tcnt != T_MID) begin
            rx_tcnt_nxt = rx_tcnt + TW'(1);
          end else if (rx_line) begin
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_tcnt_nxt  = '0;
            rx_bcnt_nxt  = '0;
            rx_state_nxt = RX_DATA;
          end
        end
      end
      default: begin
        if (tick) begin
          if (rx_tcnt != T_LAST) begin
            rx_tcnt_nxt = rx_tcnt + TW'(1);
          end else begin
            rx_tcnt_nxt = '0;
            case (rx_state)
              RX_DATA: begin
                rx_shift_nxt = {rx_line, rx_shift[DATA_W-1:1]};
                if (rx_bcnt == B_LAST) rx_state_nxt = cfg_par_en_r ? RX_PARITY : RX_STOP;
                else                   rx_bcnt_nxt  = rx_bcnt + BW'(1);
              end
              RX_PARITY: begin
                rx_par_nxt   = rx_line;
                rx_state_nxt = RX_STOP;
              end
              RX_STOP: begin
                // Only the first stop bit is checked; a second one is left to the idle line.
                if (!rx_line) begin
                  frame_evt = 1'b1;
                end else begin
                  rx_push = 1'b1;
                  par_evt = cfg_par_en_r &&
                            (rx_par != calc_par(MAX_DATA_W'(rx_shift), cfg_par_odd_r));
                end
                rx_state_nxt = RX_IDLE;
              end
              default: rx_state_nxt = RX_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun   <= 1'b0;
      rx_par_err   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_overrun   <= (rx_push && rx_full) || (rx_overrun && !err_clr);
      rx_par_err   <= par_evt || (rx_par_err && !err_clr);
      rx_frame_err <= frame_evt || (rx_frame_err && !err_clr);
    end
  end

endmodule

// File: tb/tb_uart_core_p.sv
// Scoreboard bench for uart_core_p: an 8-bit instance (optionally looped back) and a 9-bit looped-back instance.
// Stimulus queues expected RX words; monitors pop and compare whenever rx_valid is presented.
module tb_uart_core_p;

  logic        clk;
  logic        rst_n;
  logic        cfg_wr;
  logic [15:0] cfg_div;
  logic        cfg_par_en, cfg_par_odd, cfg_stop2, cfg_tx_en, cfg_rx_en;
  logic        err_clr;

  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        tx_full, tx_empty, tx_busy;
  logic        rx_rd;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_overrun, rx_par_err, rx_frame_err;
  logic        rxd, txd;

  logic        tx_wr9;
  logic [8:0]  tx_data9;
  logic        tx_full9, tx_empty9, tx_busy9;
  logic        rx_rd9;
  logic [8:0]  rx_data9;
  logic        rx_valid9, rx_overrun9, rx_par_err9, rx_frame_err9;
  logic        txd9;

  logic        loop;
  logic        rxd_drv;
  bit          mon_en;
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_q[$];
  logic [8:0]  exp9_q[$];

  assign rxd = loop ? txd : rxd_drv;

  uart_core_p #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16), .OSR(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_div(cfg_div),
    .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2),
    .cfg_tx_en(cfg_tx_en), .cfg_rx_en(cfg_rx_en),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid), .err_clr(err_clr),
    .rx_overrun(rx_overrun), .rx_par_err(rx_par_err), .rx_frame_err(rx_frame_err),
    .rxd(rxd), .txd(txd)
  );

  uart_core_p #(.DATA_W(9), .FIFO_DEPTH(4), .DIV_W(16), .OSR(16)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_div(cfg_div),
    .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2),
    .cfg_tx_en(cfg_tx_en), .cfg_rx_en(cfg_rx_en),
    .tx_wr(tx_wr9), .tx_data(tx_data9), .tx_full(tx_full9), .tx_empty(tx_empty9), .tx_busy(tx_busy9),
    .rx_rd(rx_rd9), .rx_data(rx_data9), .rx_valid(rx_valid9), .err_clr(err_clr),
    .rx_overrun(rx_overrun9), .rx_par_err(rx_par_err9), .rx_frame_err(rx_frame_err9),
    .rxd(txd9), .txd(txd9)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  function automatic logic sel_busy(input bit w);
    return w ? tx_busy9 : tx_busy;
  endfunction

  function automatic logic sel_txd(input bit w);
    return w ? txd9 : txd;
  endfunction

  initial begin
    logic [7:0] e;
    rx_rd = 1'b0;
    forever begin
      @(negedge clk);
      rx_rd = 1'b0;
      if (mon_en && rx_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got %0h expected none", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_word", int'(rx_data), int'(e));
        end
        rx_rd = 1'b1;
      end
    end
  end

  initial begin
    logic [8:0] e;
    rx_rd9 = 1'b0;
    forever begin
      @(negedge clk);
      rx_rd9 = 1'b0;
      if (rx_valid9) begin
        if (exp9_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx9_unexpected: got %0h expected none", rx_data9);
        end else begin
          e = exp9_q.pop_front();
          check("rx9_word", int'(rx_data9), int'(e));
        end
        rx_rd9 = 1'b1;
      end
    end
  end

  task automatic do_cfg(input logic [15:0] div, input logic pe, input logic po,
                        input logic s2, input logic te, input logic re);
    @(negedge clk);
    cfg_div = div; cfg_par_en = pe; cfg_par_odd = po; cfg_stop2 = s2;
    cfg_tx_en = te; cfg_rx_en = re; cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic push8(input logic [7:0] d);
    @(negedge clk);
    tx_wr = 1'b1; tx_data = d;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic push9(input logic [8:0] d);
    @(negedge clk);
    tx_wr9 = 1'b1; tx_data9 = d;
    @(negedge clk);
    tx_wr9 = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Records txd over the whole busy window; checks length, each mid-bit and that every bit is flat.
  task automatic measure_frame(input bit w, input logic [15:0] exp_bits, input int nbits, input string nm);
    logic smp [256];
    int   n;
    int   k;
    int   glitches;
    k = 0;
    while (!sel_busy(w) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("%s busy_start", nm), int'(sel_busy(w)), 1);
    n = 0;
    while (sel_busy(w) && n < 256) begin
      smp[n] = sel_txd(w);
      n++;
      @(negedge clk);
    end
    check($sformatf("%s busy_len", nm), n, nbits * 16);
    for (int b = 0; b < nbits; b++)
      check($sformatf("%s bit%0d", nm, b), int'(smp[16*b+8]), int'(exp_bits[b]));
    glitches = 0;
    for (int s = 0; s < nbits * 16; s++)
      if (smp[s] !== exp_bits[s/16]) glitches++;
    check($sformatf("%s stable", nm), glitches, 0);
  endtask

  task automatic send_rx(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd_drv = bits[i];
      repeat (16) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic wait_drain(input bit w, input int budget, input string nm);
    int k;
    k = 0;
    while ((w ? (exp9_q.size() != 0 || rx_valid9) : (exp_q.size() != 0 || rx_valid)) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("%s pending", nm), w ? exp9_q.size() : exp_q.size(), 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_div = '0;
    cfg_par_en = 1'b0; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0; cfg_tx_en = 1'b0; cfg_rx_en = 1'b0;
    err_clr = 1'b0; tx_wr = 1'b0; tx_data = '0; tx_wr9 = 1'b0; tx_data9 = '0;
    loop = 1'b0; rxd_drv = 1'b1; mon_en = 1'b1;
    repeat (3) @(negedge clk);

    check("rst txd", int'(txd), 1);
    check("rst tx_empty", int'(tx_empty), 1);
    check("rst tx_full", int'(tx_full), 0);
    check("rst tx_busy", int'(tx_busy), 0);
    check("rst rx_valid", int'(rx_valid), 0);
    check("rst flags", int'({rx_overrun, rx_par_err, rx_frame_err}), 0);
    check("rst txd9", int'(txd9), 1);
    rst_n = 1'b1;

    // Basic 8N1 frame, looped back
    loop = 1'b1;
    do_cfg(16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(8'h55);
    push8(8'h55);
    measure_frame(1'b0, 16'h02AA, 10, "tx55");
    wait_drain(1'b0, 100, "tx55 rx");

    // Odd parity on the wire, then a frame carrying the even-parity bit
    do_cfg(16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(8'h07);
    push8(8'h07);
    measure_frame(1'b0, 16'h040E, 11, "tx07odd");
    wait_drain(1'b0, 100, "tx07 rx");
    check("odd loop par_err", int'(rx_par_err), 0);
    loop = 1'b0;
    exp_q.push_back(8'h07);
    send_rx(16'h060E, 11);
    check("bad par par_err", int'(rx_par_err), 1);
    check("bad par frame_err", int'(rx_frame_err), 0);
    wait_drain(1'b0, 100, "bad par rx");
    pulse_err_clr();
    check("par_err cleared", int'(rx_par_err), 0);

    // 0xA3 with the stop bit held low
    do_cfg(16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_rx(16'h0146, 10);
    check("frame_err set", int'(rx_frame_err), 1);
    check("frame rx_valid", int'(rx_valid), 0);
    pulse_err_clr();
    check("frame_err cleared", int'(rx_frame_err), 0);

    // Five words into a four-deep RX FIFO with no reads
    mon_en = 1'b0;
    loop = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      k = 0;
      while (tx_full && k < 400) begin
        @(negedge clk);
        k++;
      end
      push8(8'(w));
    end
    k = 0;
    while (!(tx_empty && !tx_busy) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    check("overrun set", int'(rx_overrun), 1);
    check("overrun par_err", int'(rx_par_err), 0);
    for (int w = 1; w <= 4; w++) exp_q.push_back(8'(w));
    mon_en = 1'b1;
    wait_drain(1'b0, 100, "overrun rx");
    check("overrun rx_valid", int'(rx_valid), 0);
    pulse_err_clr();
    check("overrun cleared", int'(rx_overrun), 0);

    // Short low glitch on rxd
    loop = 1'b0;
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch rx_valid", int'(rx_valid), 0);
    check("glitch flags", int'({rx_overrun, rx_par_err, rx_frame_err}), 0);

    // Reset in the middle of a TX start bit, with a second word still queued
    push8(8'h3C);
    push8(8'h3D);
    k = 0;
    while (!tx_busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check("pre-reset txd", int'(txd), 0);
    #2 rst_n = 1'b0;
    #1;
    check("reset txd", int'(txd), 1);
    check("reset tx_busy", int'(tx_busy), 0);
    check("reset tx_empty", int'(tx_empty), 1);
    check("reset rx_valid", int'(rx_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nine data bits, two stop bits
    do_cfg(16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    exp9_q.push_back(9'h1AB);
    push9(9'h1AB);
    measure_frame(1'b1, 16'h0F56, 12, "tx1AB");
    wait_drain(1'b1, 200, "tx1AB rx");
    check("9b flags", int'({rx_overrun9, rx_par_err9, rx_frame_err9}), 0);

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
